clock_sequencer: RTL and testbench
==================================

# clock_sequencer

Controller for the clock unit: holds it in reset at power-up, waits for a debounced `valid`, then releases the resets of the two downstream clock domains in a fixed order. It re-sequences on loss of lock or on software request, and retries a clock unit that never locks. It sits beside `clock_unit`, runs on the system clock, and drives the reset tree of the clock0/clock1 consumers.

## Interface

Parameters:
- `LOCK_CYCLES`, default 16: consecutive synchronized-valid cycles required to declare lock; must be ≥1.
- `RST_STAGGER`, default 8: cycles between release of domain-0 and domain-1 resets; must be ≥1.
- `CU_RST_CYCLES`, default 32: length of the clock-unit reset pulse; must be ≥1.
- `TIMEOUT_CYCLES`, default 4096: cycles allowed in WAIT_LOCK before a retry.
- `MAX_RETRIES`, default 3: retries before fault.

Ports:
- `i_clock`, in, 1: system clock; the only clock.
- `i_reset`, in, 1: reset. One clock; reset is synchronous and active-low.
- `i_valid`, in, 1: clock-unit valid; asynchronous to `i_clock`, synchronized internally.
- `i_restart`, in, 1: single-cycle request to re-sequence from CU_RESET.
- `o_cu_reset`, out, 1: active-high reset to the clock unit.
- `o_rst0_n`, out, 1: active-low reset for the clock0 domain, registered.
- `o_rst1_n`, out, 1: active-low reset for the clock1 domain, registered.
- `o_ready`, out, 1: both domains released.
- `o_fault`, out, 1: retries exhausted.
- `o_retries`, out, `$clog2(MAX_RETRIES+1)`: retry count since the last reset or restart.

## Operation

- Reset (`i_reset`=0 at an edge) puts the block in the following state: CU_RESET, all counters 0, `o_cu_reset`=1, `o_rst0_n`=0, `o_rst1_n`=0, `o_ready`=0, `o_fault`=0, `o_retries`=0.
- `v_s` is `i_valid` passed through a 2-flop synchronizer.
- **CU_RESET**
  - Holds `o_cu_reset`=1 for `CU_RST_CYCLES` cycles.
  - Then goes to WAIT_LOCK, with `o_cu_reset`=0 from that edge.
- **WAIT_LOCK**
  - The lock counter increments on each `v_s`=1 and clears on `v_s`=0.
  - The timeout counter increments every cycle.
  - When the lock counter is `LOCK_CYCLES-1` and `v_s`=1: go to REL0 and set `o_rst0_n`=1.
  - Otherwise, when the timeout counter is `TIMEOUT_CYCLES-1`:
    - if `o_retries`==`MAX_RETRIES`, go to FAULT;
    - else increment `o_retries` and go to CU_RESET (`o_cu_reset`=1).
  - If lock and timeout occur on the same edge, lock wins.
- **REL0**
  - Counts `RST_STAGGER` cycles.
  - On the last one, go to RUN with `o_rst1_n`=1 and `o_ready`=1 on the same edge.
- **RUN**: steady state.
- **Loss of valid**: `v_s`=0 in REL0 or RUN causes the following on the next edge:
  - `o_rst0_n`=0, `o_rst1_n`=0, `o_ready`=0;
  - state goes to WAIT_LOCK; lock and timeout counters clear;
  - `o_retries` is unchanged.
- **FAULT**
  - `o_fault`=1, `o_cu_reset`=0, domain resets asserted.
  - Exits only on `i_restart` or `i_reset`.
- **`i_restart`** (any state):
  - next state is CU_RESET; `o_retries`=0 and `o_fault`=0;
  - all outputs take their reset values.
- **Priority**: `i_reset` > `i_restart` > loss of valid > counter expiry.
- Domain resets are never released out of order. `o_rst1_n`=1 always implies `o_rst0_n`=1.

## Timing

- All outputs are registered. No combinational path from any input to any output.
- Edge numbering: edge 0 is the first edge at which `i_valid`=1 is sampled while in WAIT_LOCK.
  - `o_rst0_n` rises after edge `LOCK_CYCLES+1`.
  - `o_rst1_n` and `o_ready` rise after edge `LOCK_CYCLES+1+RST_STAGGER`.
- Loss of valid: `i_valid` first sampled 0 at edge n drops all domain resets and `o_ready` after edge n+2.
- A `v_s` glitch shorter than `LOCK_CYCLES` cycles during WAIT_LOCK restarts the lock count without releasing any reset.
- `i_restart` sampled at edge n: `o_cu_reset`=1 and all resets asserted after edge n.

## Configuration

- Macro: `CLOCK_SEQUENCER_RETRY_EN`.
- **Defined**: timeout counter, retry logic and FAULT state are present, as described above.
- **Undefined**:
  - WAIT_LOCK waits indefinitely; no timeout counter is instantiated.
  - `o_fault` and `o_retries` are tied to 0.
  - `TIMEOUT_CYCLES` and `MAX_RETRIES` are ignored.
  - All other behaviour is identical.

## Structure

- `clock_sequencer_pkg` contains:
  - the state enum: CU_RESET, WAIT_LOCK, REL0, RUN, FAULT;
  - a counter-width helper function;
  - default parameter constants.
- Sub-module `sync_2ff`: single-bit 2-flop synchronizer, reset to 0 by the synchronous active-low reset. It is reused later for other async status inputs.
- The rest is one FSM and up to three counters (shared CU-reset/stagger counter, lock counter, timeout counter) in `clock_sequencer`.

## Test plan

All scenarios use `LOCK_CYCLES`=4, `RST_STAGGER`=3, `CU_RST_CYCLES`=5, `TIMEOUT_CYCLES`=20, `MAX_RETRIES`=2.

- **Power-up**: `i_reset` low then high.
  - `o_cu_reset` stays 1 for 5 cycles, then 0.
  - All other outputs stay at reset values.
- **Clean lock**: `i_valid` held 1 from edge 0.
  - `o_rst0_n` rises after edge 5.
  - `o_rst1_n` and `o_ready` rise after edge 8.
- **Glitch**: `i_valid` pattern 1,1,1,0,1,1,1,1.
  - No release until 4 consecutive `v_s` highs.
  - `o_rst0_n` rises 4 edges after the last rise of `v_s`.
- **Loss in RUN**: `i_valid` drops at edge n.
  - All domain resets asserted and `o_ready`=0 after edge n+2.
  - Re-lock follows the clean-lock timing.
- **Timeout/fault** (macro defined): `i_valid` held 0.
  - `o_retries` goes 1, then 2.
  - Three `o_cu_reset` pulses in total.
  - `o_fault`=1 after the third timeout.
  - `i_restart` clears `o_fault` and `o_retries`.
- **Macro undefined**: `i_valid` held 0 for 200 cycles.
  - No second `o_cu_reset` pulse.
  - `o_fault`=0 throughout.

Source files
------------

// File: rtl/clock_sequencer_pkg.sv
// Shared types, defaults and width helper for the clock-unit reset sequencer.
package clock_sequencer_pkg;

    typedef enum logic [2:0] {
        CU_RESET,
        WAIT_LOCK,
        REL0,
        RUN,
        FAULT
    } state_e;

    localparam int unsigned DEF_LOCK_CYCLES    = 16;
    localparam int unsigned DEF_RST_STAGGER    = 8;
    localparam int unsigned DEF_CU_RST_CYCLES  = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
    localparam int unsigned DEF_MAX_RETRIES    = 3;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous status inputs.
module sync_2ff (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/clock_sequencer.sv
// Clock-unit reset sequencer: CU reset pulse, lock detect, ordered domain release.
// Retry/timeout/fault logic present only when CLOCK_SEQUENCER_RETRY_EN is defined.
module clock_sequencer
    import clock_sequencer_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter int unsigned RST_STAGGER    = DEF_RST_STAGGER,
    parameter int unsigned CU_RST_CYCLES  = DEF_CU_RST_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic                                  i_clock,
    input  logic                                  i_reset,
    input  logic                                  i_valid,
    input  logic                                  i_restart,
    output logic                                  o_cu_reset,
    output logic                                  o_rst0_n,
    output logic                                  o_rst1_n,
    output logic                                  o_ready,
    output logic                                  o_fault,
    output logic [cnt_width(MAX_RETRIES + 1)-1:0] o_retries
);

`ifdef CLOCK_SEQUENCER_RETRY_EN
    localparam bit          RETRY_EN = 1'b1;
    localparam int unsigned TO_W     = cnt_width(TIMEOUT_CYCLES);
`else
    localparam bit          RETRY_EN = 1'b0;
`endif
    localparam int unsigned RT_W   = cnt_width(MAX_RETRIES + 1);
    localparam int unsigned SH_MAX = (CU_RST_CYCLES > RST_STAGGER) ? CU_RST_CYCLES : RST_STAGGER;
    localparam int unsigned SH_W   = cnt_width(SH_MAX);
    localparam int unsigned LK_W   = cnt_width(LOCK_CYCLES);

    if (LOCK_CYCLES == 0 || RST_STAGGER == 0 || CU_RST_CYCLES == 0 ||
        (RETRY_EN && TIMEOUT_CYCLES == 0)) begin : g_bad_params
        $error("clock_sequencer: cycle-count parameters must be at least 1");
    end

    logic             w_vs;
    state_e           r_state;
    state_e           w_state_nx;
    logic [SH_W-1:0]  r_sh_cnt;
    logic [SH_W-1:0]  w_sh_cnt_nx;
    logic [LK_W-1:0]  r_lock_cnt;
    logic [LK_W-1:0]  w_lock_cnt_nx;
    logic             r_cu_reset;
    logic             r_rst0_n;
    logic             r_rst1_n;
    logic             r_ready;
`ifdef CLOCK_SEQUENCER_RETRY_EN
    logic [TO_W-1:0]  r_to_cnt;
    logic [TO_W-1:0]  w_to_cnt_nx;
    logic [RT_W-1:0]  r_retries;
    logic [RT_W-1:0]  w_retries_nx;
    logic             r_fault;
`endif

    sync_2ff u_valid_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_valid),
        .o_q     (w_vs)
    );

    // State, counters and outputs; every output is decoded from the next state.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= CU_RESET;
            r_sh_cnt   <= '0;
            r_lock_cnt <= '0;
            r_cu_reset <= 1'b1;
            r_rst0_n   <= 1'b0;
            r_rst1_n   <= 1'b0;
            r_ready    <= 1'b0;
`ifdef CLOCK_SEQUENCER_RETRY_EN
            r_to_cnt   <= '0;
            r_retries  <= '0;
            r_fault    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_sh_cnt   <= w_sh_cnt_nx;
            r_lock_cnt <= w_lock_cnt_nx;
            r_cu_reset <= (w_state_nx == CU_RESET);
            r_rst0_n   <= (w_state_nx == REL0) || (w_state_nx == RUN);
            r_rst1_n   <= (w_state_nx == RUN);
            r_ready    <= (w_state_nx == RUN);
`ifdef CLOCK_SEQUENCER_RETRY_EN
            r_to_cnt   <= w_to_cnt_nx;
            r_retries  <= w_retries_nx;
            r_fault    <= (w_state_nx == FAULT);
`endif
        end
    end

    // Next-state and counter update; restart beats loss of valid beats expiry.
    always_comb begin
        w_state_nx    = r_state;
        w_sh_cnt_nx   = r_sh_cnt;
        w_lock_cnt_nx = r_lock_cnt;
`ifdef CLOCK_SEQUENCER_RETRY_EN
        w_to_cnt_nx   = r_to_cnt;
        w_retries_nx  = r_retries;
`endif
        if (i_restart) begin
            w_state_nx    = CU_RESET;
            w_sh_cnt_nx   = '0;
            w_lock_cnt_nx = '0;
`ifdef CLOCK_SEQUENCER_RETRY_EN
            w_to_cnt_nx   = '0;
            w_retries_nx  = '0;
`endif
        end else begin
            case (r_state)
                CU_RESET: begin
                    if (r_sh_cnt == SH_W'(CU_RST_CYCLES - 1)) begin
                        w_state_nx    = WAIT_LOCK;
                        w_sh_cnt_nx   = '0;
                        w_lock_cnt_nx = '0;
`ifdef CLOCK_SEQUENCER_RETRY_EN
                        w_to_cnt_nx   = '0;
`endif
                    end else begin
                        w_sh_cnt_nx = r_sh_cnt + SH_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    w_lock_cnt_nx = w_vs ? (r_lock_cnt + LK_W'(1)) : '0;
`ifdef CLOCK_SEQUENCER_RETRY_EN
                    w_to_cnt_nx   = r_to_cnt + TO_W'(1);
`endif
                    if (w_vs && (r_lock_cnt == LK_W'(LOCK_CYCLES - 1))) begin
                        w_state_nx    = REL0;
                        w_sh_cnt_nx   = '0;
                        w_lock_cnt_nx = '0;
`ifdef CLOCK_SEQUENCER_RETRY_EN
                        w_to_cnt_nx   = '0;
                    end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        w_to_cnt_nx   = '0;
                        w_lock_cnt_nx = '0;
                        w_sh_cnt_nx   = '0;
                        if (r_retries == RT_W'(MAX_RETRIES)) begin
                            w_state_nx = FAULT;
                        end else begin
                            w_retries_nx = r_retries + RT_W'(1);
                            w_state_nx   = CU_RESET;
                        end
`endif
                    end
                end
                REL0, RUN: begin
                    if (!w_vs) begin
                        w_state_nx    = WAIT_LOCK;
                        w_sh_cnt_nx   = '0;
                        w_lock_cnt_nx = '0;
`ifdef CLOCK_SEQUENCER_RETRY_EN
                        w_to_cnt_nx   = '0;
`endif
                    end else if (r_state == REL0) begin
                        if (r_sh_cnt == SH_W'(RST_STAGGER - 1)) begin
                            w_state_nx  = RUN;
                            w_sh_cnt_nx = '0;
                        end else begin
                            w_sh_cnt_nx = r_sh_cnt + SH_W'(1);
                        end
                    end
                end
                FAULT: begin
                    w_state_nx = FAULT;
                end
                default: begin
                    w_state_nx  = CU_RESET;
                    w_sh_cnt_nx = '0;
                end
            endcase
        end
    end

    assign o_cu_reset = r_cu_reset;
    assign o_rst0_n   = r_rst0_n;
    assign o_rst1_n   = r_rst1_n;
    assign o_ready    = r_ready;
`ifdef CLOCK_SEQUENCER_RETRY_EN
    assign o_fault    = r_fault;
    assign o_retries  = r_retries;
`else
    assign o_fault    = 1'b0;
    assign o_retries  = RT_W'(0);
`endif

endmodule

// File: tb/tb_clock_sequencer.sv
// Self-checking bench for clock_sequencer: directed scenarios plus random valid/restart/reset
// traffic checked every cycle against a phase-level model.
module tb_clock_sequencer;

    localparam int unsigned LK = 4;
    localparam int unsigned ST = 3;
    localparam int unsigned CR = 5;
    localparam int unsigned TO = 20;
    localparam int unsigned MR = 2;
    localparam int unsigned RW = $clog2(MR + 1);
`ifdef CLOCK_SEQUENCER_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    localparam int M_CUR  = 0;
    localparam int M_WAIT = 1;
    localparam int M_REL0 = 2;
    localparam int M_RUN  = 3;
    localparam int M_FLT  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic          restart;
    logic          cu_reset;
    logic          rst0_n;
    logic          rst1_n;
    logic          ready;
    logic          fault;
    logic [RW-1:0] retries;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int m_mode    = M_CUR;
    int m_t       = 0;
    int m_run     = 0;
    int m_retries = 0;
    bit m_s1      = 1'b0;
    bit m_s2      = 1'b0;

    always #5 clk = ~clk;

    clock_sequencer #(
        .LOCK_CYCLES    (LK),
        .RST_STAGGER    (ST),
        .CU_RST_CYCLES  (CR),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRIES    (MR)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst_n),
        .i_valid    (valid),
        .i_restart  (restart),
        .o_cu_reset (cu_reset),
        .o_rst0_n   (rst0_n),
        .o_rst1_n   (rst1_n),
        .o_ready    (ready),
        .o_fault    (fault),
        .o_retries  (retries)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Phase model: m_t = cycles spent in the current phase, m_run = consecutive synced-valid highs.
    initial forever begin : model
        bit vs;
        @(posedge clk);
        if (!rst_n) begin
            m_mode = M_CUR; m_t = 0; m_run = 0; m_retries = 0; m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            vs   = m_s2;
            m_s2 = m_s1;
            m_s1 = valid;
            if (restart) begin
                m_mode = M_CUR; m_t = 0; m_run = 0; m_retries = 0;
            end else begin
                case (m_mode)
                    M_CUR: begin
                        m_t++;
                        if (m_t == CR) begin m_mode = M_WAIT; m_t = 0; m_run = 0; end
                    end
                    M_WAIT: begin
                        m_t++;
                        m_run = vs ? m_run + 1 : 0;
                        if (m_run == LK) begin
                            m_mode = M_REL0; m_t = 0;
                        end else if (RETRY && m_t == TO) begin
                            if (m_retries == MR) m_mode = M_FLT;
                            else begin m_retries++; m_mode = M_CUR; end
                            m_t = 0;
                        end
                    end
                    M_REL0, M_RUN: begin
                        if (!vs) begin
                            m_mode = M_WAIT; m_t = 0; m_run = 0;
                        end else if (m_mode == M_REL0) begin
                            m_t++;
                            if (m_t == ST) m_mode = M_RUN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    initial forever begin : compare
        @(negedge clk);
        if (chk_en) begin
            check("cu_reset", 32'(cu_reset), 32'(m_mode == M_CUR));
            check("rst0_n",   32'(rst0_n),   32'(m_mode == M_REL0 || m_mode == M_RUN));
            check("rst1_n",   32'(rst1_n),   32'(m_mode == M_RUN));
            check("ready",    32'(ready),    32'(m_mode == M_RUN));
            check("fault",    32'(fault),    32'(m_mode == M_FLT));
            check("retries",  32'(retries),  32'(m_retries));
            check("rst_order", 32'(rst1_n & ~rst0_n), 32'd0);
        end
    end

    initial begin : stim
        bit [7:0] pat;
        int       pulses;
        int       t1;
        int       t2;
        int       fault_seen;
        int       hold;
        logic     prev;

        rst_n = 1'b0; valid = 1'b0; restart = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_cu_reset", 32'(cu_reset), 32'd1);
        check("rst_rst0_n",   32'(rst0_n),   32'd0);
        check("rst_ready",    32'(ready),    32'd0);
        check("rst_retries",  32'(retries),  32'd0);

        // Power-up: five cycles of clock-unit reset
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("pu_cu_hold", 32'(cu_reset), 32'd1);
        @(negedge clk);
        check("pu_cu_drop", 32'(cu_reset), 32'd0);
        check("pu_rst0_n",  32'(rst0_n),   32'd0);

        // Clean lock: edge 0 is the next edge
        valid = 1'b1;
        repeat (5) @(negedge clk);
        check("lock_rst0_early", 32'(rst0_n), 32'd0);
        @(negedge clk);
        check("lock_rst0_rise", 32'(rst0_n), 32'd1);
        check("lock_ready_early", 32'(ready), 32'd0);
        repeat (2) @(negedge clk);
        check("lock_rst1_early", 32'(rst1_n), 32'd0);
        @(negedge clk);
        check("lock_rst1_rise", 32'(rst1_n), 32'd1);
        check("lock_ready_rise", 32'(ready), 32'd1);

        // Loss in RUN: valid first sampled 0 at edge n
        repeat (3) @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        check("loss_ready_hold", 32'(ready), 32'd1);
        @(negedge clk);
        check("loss_ready_drop", 32'(ready), 32'd0);
        check("loss_rst0_drop",  32'(rst0_n), 32'd0);
        check("loss_rst1_drop",  32'(rst1_n), 32'd0);
        valid = 1'b1;
        repeat (5) @(negedge clk);
        check("relock_rst0_early", 32'(rst0_n), 32'd0);
        @(negedge clk);
        check("relock_rst0_rise", 32'(rst0_n), 32'd1);
        repeat (3) @(negedge clk);
        check("relock_ready", 32'(ready), 32'd1);

        // Glitch in WAIT_LOCK
        valid = 1'b0;
        repeat (3) @(negedge clk);
        pat = 8'b1111_0111;
        for (int i = 0; i < 8; i++) begin
            valid = pat[i];
            @(negedge clk);
        end
        @(negedge clk);
        check("glitch_rst0_early", 32'(rst0_n), 32'd0);
        @(negedge clk);
        check("glitch_rst0_rise", 32'(rst0_n), 32'd1);
        repeat (5) @(negedge clk);

        // Timeouts with valid held low, starting from a restart
        valid = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_cu", 32'(cu_reset), 32'd1);
        check("restart_rst0", 32'(rst0_n), 32'd0);
        pulses = 1; prev = 1'b1; t1 = 0; t2 = 0; fault_seen = 0;
`ifdef CLOCK_SEQUENCER_RETRY_EN
        for (int i = 1; i < 300 && !fault; i++) begin
            @(negedge clk);
            if (cu_reset && !prev) pulses++;
            prev = cu_reset;
            if (retries == RW'(1) && t1 == 0) t1 = i;
            if (retries == RW'(2) && t2 == 0) t2 = i;
        end
        check("to_fault_set",  32'(fault),   32'd1);
        check("to_cu_pulses",  32'(pulses),  32'd3);
        check("to_retries",    32'(retries), 32'd2);
        check("to_retry_order", 32'(t1 > 0 && t2 > t1), 32'd1);
        repeat (10) @(negedge clk);
        check("fault_sticky", 32'(fault), 32'd1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("fault_clr",   32'(fault),    32'd0);
        check("retries_clr", 32'(retries),  32'd0);
        check("fault_cu",    32'(cu_reset), 32'd1);
`else
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cu_reset && !prev) pulses++;
            prev = cu_reset;
            if (fault) fault_seen++;
        end
        check("noretry_pulses", 32'(pulses), 32'd1);
        check("noretry_fault",  32'(fault_seen), 32'd0);
        check("noretry_cu_low", 32'(cu_reset), 32'd0);
`endif

        // Random traffic, mostly-high valid in runs, rare restart and reset
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                valid = ($urandom_range(0, 9) < 7);
                hold  = int'($urandom_range(1, 30));
            end
            hold--;
            restart = ($urandom_range(0, 99) == 0);
            rst_n   = ($urandom_range(0, 599) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1; restart = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
